// File: rtl/sar_adc_conv_ctrl_if.sv
// ============================================================================
// Module   : sar_adc_conv_ctrl_if
// Brief    : Control, ADC and result-stream signals of the SAR ADC controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sar_adc_conv_ctrl_if #(
  parameter int unsigned N_BITS = 10
) ();
  logic              start;
  logic              continuous;
  logic              adc_hold;
  logic              adc_eoc;
  logic [N_BITS-1:0] adc_result;
  logic [N_BITS-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              timeout_err;
  logic              overflow_err;
  logic              clear_err;

  modport master (
    input  start, continuous, adc_eoc, adc_result, res_ready, clear_err,
    output adc_hold, res_data, res_valid, busy, timeout_err, overflow_err
  );

  modport slave (
    output start, continuous, adc_eoc, adc_result, res_ready, clear_err,
    input  adc_hold, res_data, res_valid, busy, timeout_err, overflow_err
  );
endinterface

`default_nettype wire

// File: rtl/sar_adc_conv_ctrl.sv
// ============================================================================
// Module   : sar_adc_conv_ctrl
// Brief    : SAR ADC conversion sequencer with result FIFO and sticky errors.
//            Optional sample averaging enabled by macro SAR_CTRL_AVG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sar_adc_conv_ctrl #(
  parameter int unsigned N_BITS      = 10,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned EOC_TIMEOUT = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic                clk,
  input  logic                reset,
  sar_adc_conv_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_CONVERT = 3'd2,
    S_CAPTURE = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  localparam int unsigned c_CNT_MAX = (EOC_TIMEOUT > HOLD_CYCLES) ? EOC_TIMEOUT : HOLD_CYCLES;
  localparam int unsigned c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int unsigned c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(EOC_TIMEOUT - 2);
  localparam logic [c_PTR_W:0]   c_FULL      = (c_PTR_W + 1)'(FIFO_DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                w_timeout;
  logic [N_BITS-1:0]   r_sample;

  logic [N_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic                w_full;
  logic                w_pop;
  logic                w_push_req;
  logic                w_push;
  logic                w_drop;
  logic [N_BITS-1:0]   w_push_data;
  logic                r_timeout_err;
  logic                r_overflow_err;

  // The wait counter is shared by HOLD, CONVERT and RECOVER; it restarts on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start || bus.continuous) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_CONVERT: begin
        if (bus.adc_eoc) begin
          w_state_nxt = S_CAPTURE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_RECOVER;
        w_cnt_nxt   = '0;
      end
      S_RECOVER: begin
        if (!bus.adc_eoc) begin
          w_state_nxt = bus.continuous ? S_HOLD : S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sample <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_CONVERT && bus.adc_eoc) begin
        r_sample <= bus.adc_result;
      end
    end
  end

`ifdef SAR_CTRL_AVG_EN
  localparam int unsigned c_ACC_W = N_BITS + AVG_LOG2;
  localparam int unsigned c_AVG_W = AVG_LOG2 + 1;
  localparam logic [c_AVG_W-1:0] c_AVG_LAST = c_AVG_W'((1 << AVG_LOG2) - 1);

  logic [c_ACC_W-1:0] r_acc;
  logic [c_ACC_W-1:0] w_acc_sum;
  logic [c_AVG_W-1:0] r_avg_cnt;

  assign w_acc_sum   = r_acc + c_ACC_W'(r_sample);
  assign w_push_req  = (r_state == S_CAPTURE) && (r_avg_cnt == c_AVG_LAST);
  assign w_push_data = N_BITS'(w_acc_sum >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (!reset || w_timeout) begin
      r_acc     <= '0;
      r_avg_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      if (r_avg_cnt == c_AVG_LAST) begin
        r_acc     <= '0;
        r_avg_cnt <= '0;
      end else begin
        r_acc     <= w_acc_sum;
        r_avg_cnt <= r_avg_cnt + 1'b1;
      end
    end
  end
`else
  assign w_push_req  = (r_state == S_CAPTURE);
  assign w_push_data = r_sample;
`endif

  // A pop in the capture cycle frees the slot, so a full FIFO still accepts the push.
  assign w_full = (r_count == c_FULL);
  assign w_pop  = (r_count != '0) && bus.res_ready;
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timeout_err  <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (bus.clear_err) begin
        r_timeout_err <= 1'b0;
      end
      if (w_drop) begin
        r_overflow_err <= 1'b1;
      end else if (bus.clear_err) begin
        r_overflow_err <= 1'b0;
      end
    end
  end

  assign bus.adc_hold     = (r_state == S_HOLD) || (r_state == S_CONVERT);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.res_valid    = (r_count != '0);
  assign bus.res_data     = r_mem[r_rd_ptr];
  assign bus.timeout_err  = r_timeout_err;
  assign bus.overflow_err = r_overflow_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_conv_ctrl.sv
// ============================================================================
// Module   : tb_sar_adc_conv_ctrl
// Brief    : Directed self-checking bench for sar_adc_conv_ctrl with an ADC model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sar_adc_conv_ctrl;

  localparam int unsigned N_BITS = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sar_adc_conv_ctrl_if #(.N_BITS(N_BITS)) bus ();

  sar_adc_conv_ctrl #(
    .N_BITS      (N_BITS),
    .HOLD_CYCLES (2),
    .EOC_TIMEOUT (64),
    .FIFO_DEPTH  (4),
    .AVG_LOG2    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic              adc_en    = 1'b0;
  int                eoc_delay = 10;
  int                hold_cnt  = 0;
  logic [N_BITS-1:0] seq [$];

  // ADC model: eoc pulses for one cycle eoc_delay cycles after hold rises.
  initial begin
    bus.adc_eoc    = 1'b0;
    bus.adc_result = '0;
    forever begin
      @(negedge clk);
      if (bus.adc_eoc) begin
        bus.adc_eoc = 1'b0;
        hold_cnt    = 0;
      end else if (bus.adc_hold && adc_en) begin
        hold_cnt++;
        if (hold_cnt == eoc_delay) begin
          bus.adc_eoc    = 1'b1;
          bus.adc_result = (seq.size() != 0) ? seq.pop_front() : '0;
        end
      end else begin
        hold_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic shot(input logic [N_BITS-1:0] v);
    seq.push_back(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.res_ready  = 1'b0;
    bus.clear_err  = 1'b0;

    reset = 1'b0;
    tick();
    tick();
    chk("rst_hold",  {31'd0, bus.adc_hold},     32'd0);
    chk("rst_valid", {31'd0, bus.res_valid},    32'd0);
    chk("rst_data",  {22'd0, bus.res_data},     32'd0);
    chk("rst_busy",  {31'd0, bus.busy},         32'd0);
    chk("rst_tmo",   {31'd0, bus.timeout_err},  32'd0);
    chk("rst_ovf",   {31'd0, bus.overflow_err}, 32'd0);
    reset = 1'b1;
    tick();

`ifdef SAR_CTRL_AVG_EN
    adc_en    = 1'b1;
    eoc_delay = 3;
    shot(10'd100);
    chk("avg_none1", {31'd0, bus.res_valid}, 32'd0);
    shot(10'd101);
    chk("avg_none2", {31'd0, bus.res_valid}, 32'd0);
    shot(10'd102);
    chk("avg_none3", {31'd0, bus.res_valid}, 32'd0);
    shot(10'd104);
    chk("avg_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("avg_data",  {22'd0, bus.res_data},  32'd101);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("avg_single", {31'd0, bus.res_valid}, 32'd0);
`else
    // Single shot: eoc 10 cycles after hold rises.
    adc_en    = 1'b1;
    eoc_delay = 10;
    seq.push_back(10'h2A5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    for (int c = 1; c <= 10; c++) begin
      chk("t1_hold_hi", {31'd0, bus.adc_hold}, 32'd1);
      tick();
    end
    chk("t1_hold_lo",  {31'd0, bus.adc_hold},  32'd0);
    chk("t1_valid_k1", {31'd0, bus.res_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("t1_data",  {22'd0, bus.res_data},  32'h2A5);
    tick();
    chk("t1_idle", {31'd0, bus.busy}, 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t1_popped", {31'd0, bus.res_valid}, 32'd0);

    // Timeout: eoc never comes; hold lasts HOLD_CYCLES + EOC_TIMEOUT-1 cycles.
    adc_en    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.adc_hold && n < 200) begin
      n++;
      tick();
    end
    chk("t2_hold_len", n, 32'd65);
    chk("t2_tmo",      {31'd0, bus.timeout_err}, 32'd1);
    chk("t2_busy",     {31'd0, bus.busy},        32'd0);
    chk("t2_empty",    {31'd0, bus.res_valid},   32'd0);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("t2_clear", {31'd0, bus.timeout_err}, 32'd0);

    // Continuous with a stalled consumer: fifth result overflows.
    adc_en    = 1'b1;
    eoc_delay = 3;
    for (int i = 1; i <= 5; i++) seq.push_back(N_BITS'(i));
    bus.continuous = 1'b1;
    n = 0;
    while (seq.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    bus.continuous = 1'b0;
    wait_idle();
    chk("t3_ovf", {31'd0, bus.overflow_err}, 32'd1);
    chk("t3_tmo", {31'd0, bus.timeout_err},  32'd0);
    bus.res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("t3_data",  {22'd0, bus.res_data},  i);
      tick();
    end
    bus.res_ready = 1'b0;
    chk("t3_drained", {31'd0, bus.res_valid}, 32'd0);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("t3_clear", {31'd0, bus.overflow_err}, 32'd0);

    // Reset in the middle of CONVERT.
    adc_en    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_pre_hold", {31'd0, bus.adc_hold}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t4_hold",  {31'd0, bus.adc_hold},     32'd0);
    chk("t4_busy",  {31'd0, bus.busy},         32'd0);
    chk("t4_valid", {31'd0, bus.res_valid},    32'd0);
    chk("t4_tmo",   {31'd0, bus.timeout_err},  32'd0);
    chk("t4_ovf",   {31'd0, bus.overflow_err}, 32'd0);
    tick();
    tick();
    chk("t4_stays_idle", {31'd0, bus.busy}, 32'd0);

    // Push and pop together at full: no overflow, occupancy stays 4.
    adc_en    = 1'b1;
    eoc_delay = 3;
    shot(10'd11);
    shot(10'd12);
    shot(10'd13);
    shot(10'd14);
    seq.push_back(10'd15);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.adc_eoc && n < 100) begin
      tick();
      n++;
    end
    chk("t5_capture_reached", {31'd0, bus.adc_eoc}, 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("t5_no_ovf", {31'd0, bus.overflow_err}, 32'd0);
    wait_idle();
    bus.res_ready = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      chk("t5_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("t5_data",  {22'd0, bus.res_data},  i);
      tick();
    end
    bus.res_ready = 1'b0;
    chk("t5_count4", {31'd0, bus.res_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sar_adc_conv_ctrl.md
Name: sar_adc_conv_ctrl

Overview:
Initiator-side controller for the sar_adc__N_BITS_10 conversion interface. It asserts the ADC hold/start line, waits for end-of-conversion (eoc) and captures the digital result. Results go into a small FIFO with a valid/ready output toward downstream logic. It supports single-shot and continuous conversion modes, an eoc timeout, and a sticky overflow/error flag.

Parameters:
N_BITS, 10, ADC result width
HOLD_CYCLES, 2, cycles hold is asserted before eoc is watched (>=1)
EOC_TIMEOUT, 64, max cycles in CONVERT before a timeout error (>=2)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
AVG_LOG2, 2, log2 of samples averaged (used only with SAR_CTRL_AVG_EN)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous active-low reset (0 = reset)
start  input  1  single-shot request pulse, honoured in IDLE only
continuous  input  1  level: 1 = auto-restart after each capture
adc_hold  output  1  drives ADC input_hold_digital
adc_eoc  input  1  ADC eoc
adc_result  input  N_BITS  ADC output_result_digital
res_data  output  N_BITS  FIFO head data
res_valid  output  1  FIFO non-empty
res_ready  input  1  consumer accept; pop when res_valid & res_ready
busy  output  1  FSM not in IDLE
timeout_err  output  1  sticky; set on eoc timeout
overflow_err  output  1  sticky; set when a capture finds the FIFO full
clear_err  input  1  clears both sticky flags (set has priority the same cycle)

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE; adc_hold=0; FIFO empty; res_valid=0; res_data=0; busy=0; both error flags=0; counters=0. Reset mid-conversion aborts with no capture.
- FSM states: IDLE, HOLD, CONVERT, CAPTURE, RECOVER.
- IDLE: if start|continuous -> HOLD, adc_hold<=1. busy=0.
- HOLD: adc_hold=1 for exactly HOLD_CYCLES cycles, then -> CONVERT. adc_eoc is ignored here.
- CONVERT: adc_hold stays 1. Wait counter increments each cycle.
  - adc_eoc==1 -> CAPTURE; adc_result is sampled that same cycle.
  - counter reaches EOC_TIMEOUT-1 without eoc -> timeout_err<=1, adc_hold<=0, -> IDLE. No FIFO write.
- CAPTURE (1 cycle): adc_hold<=0.
  - FIFO not full: push the sampled value.
  - FIFO full: drop the sample, overflow_err<=1.
  - If FIFO full and popped in the same cycle, push succeeds with no overflow.
  - -> RECOVER.
- RECOVER: wait until adc_eoc==0, with the timeout rule (flag set, -> IDLE).
  - eoc low and continuous==1 -> HOLD.
  - Otherwise -> IDLE.
- Latency: start at cycle 0 -> adc_hold high at cycle 1. eoc seen at cycle k -> res_valid high at cycle k+2 when the FIFO was empty.
- FIFO: registered output; res_data reflects the head. A push and a pop in the same cycle are both performed, and count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- start while busy is ignored, not queued. Deasserting continuous mid-conversion finishes the current conversion, then goes to IDLE.
- adc_result is treated as unsigned, and its width equals N_BITS.

Optional Feature:
Macro SAR_CTRL_AVG_EN.
- Defined:
  - Each capture adds the sample into an accumulator of width N_BITS+AVG_LOG2.
  - After 2^AVG_LOG2 captures, the accumulator is shifted right by AVG_LOG2 (truncating) and pushed to the FIFO, then cleared.
  - Intermediate captures do not push.
  - The accumulator and sample count clear on reset and on timeout.
- Undefined: every capture is pushed directly, and there is no accumulator logic.

Test Plan:
1. Single shot: reset low 2 cycles, start pulse, ADC model asserts eoc 10 cycles after hold with result 0x2A5 -> adc_hold high exactly from start+1 to the eoc cycle; res_valid=1 with res_data=0x2A5 at eoc+2; busy returns to 0.
2. Timeout: start, eoc never asserts, EOC_TIMEOUT=64 -> timeout_err=1 and adc_hold=0 after 2+63 hold cycles; FIFO stays empty. clear_err -> flag 0.
3. Continuous with res_ready=0, FIFO_DEPTH=4, results 1..5 -> FIFO holds 1,2,3,4 and overflow_err=1. Raising res_ready pops 1,2,3,4 in order.
4. Reset mid-CONVERT: reset=0 while adc_hold=1 -> next cycle adc_hold=0, busy=0, no FIFO entry, flags 0.
5. Simultaneous push/pop at full with res_ready=1 -> no overflow; count stays 4.
6. SAR_CTRL_AVG_EN, AVG_LOG2=2, samples 100,101,102,104 -> one entry of 101; no entries after the first three samples.
